sha256_sched_ctrl: RTL and testbench

- Sequences one 512-bit block through the SHA-256 message scheduler.
- Accepts 16 message words over a valid/ready stream and writes them into the scheduler at addresses 0..15.
- Then steps round_t 0..63, waiting the scheduler's expansion latency for t>=16.
- Gives the compression core a per-round Wt-valid strobe and signals done when the block ends.

---
 rtl/sha256_sched_ctrl.sv | 148 ++++++++++++++
 tb/tb_sha256_sched_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_sched_ctrl.sv
// Load/round sequencer for one 512-bit block through the SHA-256 message scheduler.
// Optional abort input is enabled by defining SHA256_SCHED_CTRL_ABORT_EN.
module sha256_sched_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int EXP_CYCLES = 5,
    parameter int MSG_WORDS  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
`ifdef SHA256_SCHED_CTRL_ABORT_EN
    input  logic        abort,
`endif
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_data,
    output logic        sched_start_new_block,
    output logic        sched_stn,
    output logic [5:0]  sched_round_t,
    output logic [31:0] sched_word_in,
    output logic [3:0]  sched_word_addr,
    output logic        sched_we,
    output logic        wt_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] r_state;
    logic [3:0] r_wcnt;
    logic [3:0] r_dcnt;
    logic [5:0] r_round_t;
    logic       r_start_nb;
    logic       r_stn;
    logic       r_wt_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_abort;
    logic       w_beat;
    logic [5:0] w_t_next;
    logic [3:0] w_dcnt_next;

`ifdef SHA256_SCHED_CTRL_ABORT_EN
    assign w_abort = abort & (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // An aborting cycle never completes a handshake, so no word is written.
    assign msg_ready       = (r_state == S_LOAD) & ~w_abort;
    assign w_beat          = msg_valid & msg_ready;
    assign sched_we        = w_beat;
    assign sched_word_in   = w_beat ? msg_data : 32'd0;
    assign sched_word_addr = w_beat ? r_wcnt : 4'd0;

    assign w_t_next    = r_round_t + 6'd1;
    assign w_dcnt_next = r_dcnt + 4'd1;

    assign sched_start_new_block = r_start_nb;
    assign sched_stn             = r_stn;
    assign sched_round_t         = r_round_t;
    assign wt_valid              = r_wt_valid;
    assign busy                  = r_busy;
    assign done                  = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 4'd0;
            r_dcnt     <= 4'd0;
            r_round_t  <= 6'd0;
            r_start_nb <= 1'b0;
            r_stn      <= 1'b0;
            r_wt_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_abort) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 4'd0;
            r_dcnt     <= 4'd0;
            r_round_t  <= 6'd0;
            r_start_nb <= 1'b0;
            r_stn      <= 1'b0;
            r_wt_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_wcnt     <= 4'd0;
                        r_dcnt     <= 4'd0;
                        r_round_t  <= 6'd0;
                        r_start_nb <= 1'b1;
                        r_stn      <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_wcnt <= r_wcnt + 4'd1;
                        if (r_wcnt == 4'(MSG_WORDS - 1)) begin
                            // Round 0 has a one-cycle hold, so its strobe starts immediately.
                            r_state    <= S_ROUND;
                            r_start_nb <= 1'b0;
                            r_stn      <= 1'b1;
                            r_round_t  <= 6'd0;
                            r_dcnt     <= 4'd0;
                            r_wt_valid <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    if (r_wt_valid) begin
                        if (r_round_t == 6'(NUM_ROUNDS - 1)) begin
                            r_state    <= S_DONE;
                            r_wt_valid <= 1'b0;
                            r_stn      <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_round_t  <= w_t_next;
                            r_dcnt     <= 4'd0;
                            r_stn      <= (w_t_next < 6'd16);
                            r_wt_valid <= (w_t_next < 6'd16);
                        end
                    end else begin
                        // Only expansion rounds (t>=16) ever wait here.
                        r_dcnt     <= w_dcnt_next;
                        r_wt_valid <= (w_dcnt_next == 4'(EXP_CYCLES - 1));
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Randomized self-checking bench for sha256_sched_ctrl against a per-cycle round-schedule model.
module tb_sha256_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
`ifdef SHA256_SCHED_CTRL_ABORT_EN
    logic        abort;
`endif
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_data;
    logic        sched_start_new_block;
    logic        sched_stn;
    logic [5:0]  sched_round_t;
    logic [31:0] sched_word_in;
    logic [3:0]  sched_word_addr;
    logic        sched_we;
    logic        wt_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [5:0] idle_t;

    always #5 clk = ~clk;

    sha256_sched_ctrl dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start                 (start),
`ifdef SHA256_SCHED_CTRL_ABORT_EN
        .abort                 (abort),
`endif
        .msg_valid             (msg_valid),
        .msg_ready             (msg_ready),
        .msg_data              (msg_data),
        .sched_start_new_block (sched_start_new_block),
        .sched_stn             (sched_stn),
        .sched_round_t         (sched_round_t),
        .sched_word_in         (sched_word_in),
        .sched_word_addr       (sched_word_addr),
        .sched_we              (sched_we),
        .wt_valid              (wt_valid),
        .busy                  (busy),
        .done                  (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round schedule: round t lasts 1 cycle for t<16 and 5 cycles otherwise; strobe on its last cycle.
    function automatic void round_at(input int o, output int t, output bit wv);
        int s;
        int l;
        s  = 0;
        t  = 63;
        wv = 1'b0;
        for (int k = 0; k < 64; k++) begin
            l = (k < 16) ? 1 : 5;
            if (o < s + l) begin
                t  = k;
                wv = (o == s + l - 1);
                return;
            end
            s += l;
        end
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, msg_ready, 0);
        check({tag, "_snb"}, sched_start_new_block, 0);
        check({tag, "_stn"}, sched_stn, 0);
        check({tag, "_t"}, sched_round_t, 0);
        check({tag, "_wdata"}, sched_word_in, 0);
        check({tag, "_waddr"}, sched_word_addr, 0);
        check({tag, "_we"}, sched_we, 0);
        check({tag, "_wt"}, wt_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic check_idle();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ready", msg_ready, 0);
        check("idle_we", sched_we, 0);
        check("idle_wt", wt_valid, 0);
        check("idle_snb", sched_start_new_block, 0);
        check("idle_t", sched_round_t, idle_t);
    endtask

    task automatic run_block(input bit seq_data, input int stall_pos, input int stall_len,
                             input bit rnd_stall, input int glitch_t, input int rst_t,
                             input int abort_w);
        logic [31:0] words [16];
        int n;
        int left;
        int wt_cnt;
        int t;
        bit v;
        bit wv;
        bit ab;
        for (int i = 0; i < 16; i++) words[i] = seq_data ? 32'h10 + 32'(i) : $urandom;

        // IDLE cycle with start and a valid word: the word must not be taken yet.
        @(negedge clk);
        start     = 1'b1;
        msg_valid = 1'b1;
        msg_data  = 32'hDEAD_BEEF;
        #1;
        check_idle();

        n    = 0;
        left = stall_len;
        for (int c = 0; c < 200 && n < 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == stall_pos && left > 0) begin
                v = 1'b0;
                left--;
            end else if (rnd_stall) begin
                v = ($urandom_range(0, 2) != 0);
            end else begin
                v = 1'b1;
            end
            ab = (n == abort_w);
`ifdef SHA256_SCHED_CTRL_ABORT_EN
            abort = ab;
`endif
            msg_valid = v;
            msg_data  = v ? words[n] : $urandom;
            #1;
            check("load_busy", busy, 1);
            check("load_snb", sched_start_new_block, 1);
            check("load_stn", sched_stn, 1);
            check("load_wt", wt_valid, 0);
            check("load_done", done, 0);
            if (ab) begin
                check("abort_we", sched_we, 0);
                @(negedge clk);
`ifdef SHA256_SCHED_CTRL_ABORT_EN
                abort = 1'b0;
`endif
                msg_valid = 1'b0;
                idle_t    = 6'd0;
                #1;
                check_idle();
                check("abort_stn", sched_stn, 0);
                return;
            end
            check("load_ready", msg_ready, 1);
            check("load_we", sched_we, 32'(v));
            if (v) begin
                check("load_addr", sched_word_addr, n);
                check("load_data", sched_word_in, words[n]);
                n++;
            end
        end
        check("load_count", n, 16);
        if (n < 16) return;

        wt_cnt = 0;
        for (int o = 0; o < 256; o++) begin
            @(negedge clk);
            round_at(o, t, wv);
            start     = (t == glitch_t);
            msg_valid = $urandom_range(0, 1);
            msg_data  = $urandom;
            #1;
            check("rnd_t", sched_round_t, t);
            check("rnd_wt", wt_valid, 32'(wv));
            check("rnd_stn", sched_stn, 32'(t < 16));
            check("rnd_snb", sched_start_new_block, 0);
            check("rnd_busy", busy, 1);
            check("rnd_done", done, 0);
            check("rnd_ready", msg_ready, 0);
            check("rnd_we", sched_we, 0);
            if (wt_valid === 1'b1) wt_cnt++;
            if (t == rst_t) begin
                start   = 1'b0;
                reset_n = 1'b0;
                #1;
                check_zero("midrst");
                @(negedge clk);
                reset_n = 1'b1;
                idle_t  = 6'd0;
                return;
            end
        end
        @(negedge clk);
        start     = 1'b0;
        msg_valid = 1'b0;
        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_t", sched_round_t, 63);
        check("done_wt", wt_valid, 0);
        check("wt_pulses", wt_cnt, 64);
        @(negedge clk);
        idle_t = 6'd63;
        #1;
        check_idle();
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        msg_valid = 1'b0;
        msg_data  = 32'd0;
`ifdef SHA256_SCHED_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        idle_t    = 6'd0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        run_block(1'b1, -1, 0, 1'b0, -1, -1, -1);
        run_block(1'b1, 6, 3, 1'b0, -1, -1, -1);
        run_block(1'b0, -1, 0, 1'b1, 30, -1, -1);
        run_block(1'b0, -1, 0, 1'b1, -1, 40, -1);
        run_block(1'b0, -1, 0, 1'b0, -1, -1, -1);
`ifdef SHA256_SCHED_CTRL_ABORT_EN
        run_block(1'b0, -1, 0, 1'b0, -1, -1, 7);
        run_block(1'b0, -1, 0, 1'b1, -1, -1, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
